// File: rtl/apb_rr_arbiter_if.sv
// APB master-port bundle between the round-robin arbiter and the downstream slave.
// The arbiter drives select/enable/command and the slave drives ready/data/error.
interface apb_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter that sequences one APB transfer at a time,
// with a wait-state watchdog that forces an error when the slave never answers.
module apb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int CW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic            req0_write,
  input  logic [DW-1:0]   req0_wdata,
  output logic            req0_done,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic            req1_write,
  input  logic [DW-1:0]   req1_wdata,
  output logic            req1_done,
  output logic [DW-1:0]   rdata,
  output logic            slverr,
  output logic [1:0]      grant,
  apb_rr_arbiter_if.master apb
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  localparam bit            WD_ON   = (TIMEOUT != 0);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          last;
  logic [CW-1:0] count;
  logic          pick1;

  // On a tie the requester that did not win last time takes the bus.
  always_comb begin
    pick1 = req1_valid && (!req0_valid || !last);
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch sees the values from before this edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      last        <= 1'b1;
      count       <= '0;
      grant       <= 2'b00;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      rdata       <= '0;
      slverr      <= 1'b0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.paddr   <= '0;
      apb.pwrite  <= 1'b0;
      apb.pwdata  <= '0;
    end else begin
      // NOTE: done pulses default low here so they can only last one cycle.
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          count <= '0;
          if (req0_valid || req1_valid) begin
            apb.paddr  <= pick1 ? req1_addr  : req0_addr;
            apb.pwrite <= pick1 ? req1_write : req0_write;
            apb.pwdata <= pick1 ? req1_wdata : req0_wdata;
            grant      <= pick1 ? 2'b10 : 2'b01;
            last       <= pick1;
            apb.psel   <= 1'b1;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          apb.penable <= 1'b1;
          state       <= S_ACCESS;
        end
        S_ACCESS: begin
          // Slave response beats the watchdog when both land in the same cycle.
          if (apb.pready) begin
            rdata       <= apb.prdata;
            slverr      <= apb.pslverr;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            req0_done   <= grant[0];
            req1_done   <= grant[1];
            state       <= S_DONE;
          end else if (WD_ON && count == WD_LAST) begin
            slverr      <= 1'b1;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            req0_done   <= grant[0];
            req1_done   <= grant[1];
            state       <= S_DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_DONE: begin
          grant <= 2'b00;
          count <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for a single APB master port in the AHB-Lite to APB bridge. It grants one requester at a time and latches its command into registered address, control and data stages. It then drives the APB SETUP and ACCESS phases and returns read data and error status to the granted requester. A wait-state watchdog ends any transfer whose slave never asserts pready.

Parameters:
AW, 32, address width
DW, 32, data width
CW, 8, watchdog counter width
TIMEOUT, 16, maximum ACCESS cycles before forced termination; 0 disables watchdog; must be < 2^CW

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 command pending; held until req0_done
req0_addr  in  AW  requester 0 address
req0_write  in  1  requester 0 direction, 1=write
req0_wdata  in  DW  requester 0 write data
req0_done  out  1  one-cycle completion pulse to requester 0
req1_valid, req1_addr, req1_write, req1_wdata, req1_done: same as requester 0, for requester 1
rdata  out  DW  read data of last completed transfer, valid with reqN_done
slverr  out  1  error of last completed transfer, valid with reqN_done
grant  out  2  one-hot owner of the current transfer, 00 when idle
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  AW  APB address
pwrite  out  1  APB direction
pwdata  out  DW  APB write data
pready  in  1  APB ready
prdata  in  DW  APB read data
pslverr  in  1  APB error

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high. The outputs below are registered.
- Reset values: all outputs 0. State=IDLE. Round-robin pointer last=1, so requester 0 wins the first tie. Watchdog count=0.
- IDLE:
  - If any reqN_valid is high, select a winner: the only valid requester, or, when both are valid, the one that is not last.
  - Latch the winner's addr/write/wdata into paddr/pwrite/pwdata.
  - Set grant one-hot, set last=winner, go to SETUP.
  - If no requester is valid, stay in IDLE with psel=0.
- SETUP: psel=1, penable=0, one cycle, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1, and the watchdog counts each cycle.
  - On pready=1: capture prdata into rdata and pslverr into slverr, go to DONE.
  - If TIMEOUT!=0 and count reaches TIMEOUT-1 with pready=0: force slverr=1, leave rdata unchanged, go to DONE.
- DONE:
  - psel=0, penable=0, reqN_done=1 for the granted requester only, for exactly one cycle.
  - Requests are not sampled in this state. Next state is IDLE, where grant clears to 00 and the count clears.
- paddr/pwrite/pwdata hold their values from SETUP through DONE. They change only on the next grant.
- Latency: valid sampled in IDLE at edge 0 → SETUP at cycle 1 → ACCESS at cycle 2 → with zero wait states, done at cycle 3.
  - Minimum 4 cycles per transfer including the return to IDLE.
  - Each wait state adds 1 cycle.
- Requester rules:
  - Changing a requester's command while valid and not yet done is illegal; the latched copy is used.
  - After done the requester may drop valid or present a new command. A new command is arbitrated in the following IDLE cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,… No starvation.
- Simultaneous events: a requester that asserts valid during SETUP, ACCESS or DONE waits until IDLE. pready in SETUP is ignored. pready and timeout in the same cycle resolve as pready, so slave data and error win.
- Reset mid-transfer: psel, penable and done drop immediately (asynchronously). The transfer is abandoned, with no done pulse. Round-robin returns to last=1.
- rdata/slverr are undefined-by-contract for write transfers except that slverr reflects pslverr.

Test Plan:
1. Reset, then req0 read addr=0x10, slave pready=1 at the first ACCESS cycle with prdata=0xCAFE0001 → psel rises at cycle 1, penable at cycle 2, req0_done at cycle 3 with rdata=0xCAFE0001 and slverr=0, grant=01 during the transfer.
2. req0 and req1 both valid continuously, writes with pwdata 0xA0 and 0xB0 → APB sees 0xA0, 0xB0, 0xA0, 0xB0. Done pulses alternate. Each transfer takes 4 cycles.
3. req1 write, slave holds pready=0 for 3 cycles, then asserts pready with pslverr=1 → penable high for 4 cycles, req1_done with slverr=1, pwdata stable throughout.
4. TIMEOUT=16, pready stuck at 0 → penable high exactly 16 cycles, then psel/penable drop, done with slverr=1, rdata unchanged from the previous transfer.
5. Assert rst during ACCESS of a req0 transfer → psel/penable/grant go to 0 without waiting for clk. No req0_done. The first grant after reset goes to req0 even if req1 was last granted.
6. req1 asserts valid during req0's DONE cycle, req0 drops valid after its done → req1 is granted at the following IDLE cycle and its SETUP starts one cycle later.
